// File: rtl/io_interrupt_controller_if.sv
// Side-band IO strobes, address and interrupt request shared between the control unit and
// the interrupt controller. The data bus stays a separate inout net on the controller.
interface io_interrupt_controller_if;
    logic        io_read;
    logic        io_write;
    logic        io_push;
    logic        io_store_retaddr;
    logic        io_push_retaddr;
    logic        io_push_ints;
    logic        io_push_int_addr;
    logic [15:0] d_addr;
    logic        io_interrupt;

    modport master (
        output io_read, io_write, io_push, io_store_retaddr, io_push_retaddr,
               io_push_ints, io_push_int_addr, d_addr,
        input  io_interrupt
    );

    modport slave (
        input  io_read, io_write, io_push, io_store_retaddr, io_push_retaddr,
               io_push_ints, io_push_int_addr, d_addr,
        output io_interrupt
    );
endinterface

// File: rtl/io_interrupt_controller.sv
// Interrupt controller answering the CPU side-band IO strobes over d_bus/d_addr.
// Define INTC_LEVEL_TRIG_EN to add the TRIG register (per-line level triggering).
module io_interrupt_controller #(
    parameter int unsigned NUM_IRQ   = 8,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    io_interrupt_controller_if.slave io,
    inout  wire  [15:0]              d_bus,
    input  logic [NUM_IRQ-1:0]       irq_in
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state, state_next;

    logic [NUM_IRQ-1:0] mask, pending, pending_next, irq_prev;
    logic [NUM_IRQ-1:0] masked, rise, level_set, w1c, ack_bit;
    logic [15:0]        vbase, retaddr, read_hold, vector, reg_rdata, bus_out;
    logic [3:0]         addr, active_id, cur_id;
    logic               gie, irq_q, req, ack, eoi, bus_en, in_service;
    logic               unused_addr_bits;

    assign addr             = io.d_addr[3:0];
    assign unused_addr_bits = ^io.d_addr[15:4];
    assign masked           = pending & mask;
    assign req              = gie & (|masked);
    assign in_service       = (state == SERVICE);

    // Lowest set bit wins: scan from the top so the last hit is the smallest id.
    always_comb begin
        cur_id = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (masked[i-1]) cur_id = 4'(i - 1);
        end
    end

    assign vector = vbase + (16'(cur_id) << VEC_SHIFT);

`ifdef INTC_LEVEL_TRIG_EN
    logic [NUM_IRQ-1:0] trig;
    assign level_set = irq_in & trig;

    always_ff @(posedge clk) begin
        if (rst) trig <= '0;
        else if (io.io_write && addr == 4'd5) trig <= d_bus[NUM_IRQ-1:0];
    end
`else
    assign level_set = '0;
`endif

    assign rise    = irq_in & ~irq_prev;
    assign w1c     = (io.io_write && addr == 4'd1) ? d_bus[NUM_IRQ-1:0] : '0;
    assign ack     = (state == REQ) && req && io.io_push_int_addr;
    assign ack_bit = ack ? (NUM_IRQ'(1) << cur_id) : '0;
    assign eoi     = in_service && io.io_write && addr == 4'd4;
    // Acknowledge beats a level line for one cycle; a fresh edge still beats any clear.
    assign pending_next = (pending & ~w1c & ~ack_bit) | rise | (level_set & ~ack_bit);

    always_comb begin
        reg_rdata = '0;
        case (addr)
            4'd0: reg_rdata = 16'(mask);
            4'd1: reg_rdata = 16'(pending);
            4'd2: reg_rdata = vbase;
            4'd3: reg_rdata = {8'h00, active_id, 2'b00, in_service, gie};
`ifdef INTC_LEVEL_TRIG_EN
            4'd5: reg_rdata = 16'(trig);
`endif
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = REQ;
            REQ: begin
                if (!req)                     state_next = IDLE;
                else if (io.io_push_int_addr) state_next = SERVICE;
            end
            SERVICE: if (eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= 1'b0;
            irq_prev  <= '0;
            pending   <= '0;
            mask      <= '0;
            vbase     <= '0;
            gie       <= 1'b0;
            active_id <= '0;
            read_hold <= '0;
            retaddr   <= '0;
        end else begin
            irq_q    <= (state_next == REQ);
            irq_prev <= irq_in;
            pending  <= pending_next;
            if (ack)                 active_id <= cur_id;
            if (io.io_read)          read_hold <= reg_rdata;
            if (io.io_store_retaddr) retaddr   <= d_bus;
            if (io.io_write) begin
                case (addr)
                    4'd0:    mask  <= d_bus[NUM_IRQ-1:0];
                    4'd2:    vbase <= d_bus;
                    4'd3:    gie   <= d_bus[0];
                    default: ;
                endcase
            end
        end
    end

    assign io.io_interrupt = irq_q;

    always_comb begin
        bus_en  = 1'b1;
        bus_out = '0;
        if (io.io_push_int_addr)     bus_out = vector;
        else if (io.io_push_retaddr) bus_out = retaddr;
        else if (io.io_push_ints)    bus_out = 16'(masked);
        else if (io.io_push)         bus_out = read_hold;
        else                         bus_en  = 1'b0;
    end

    assign d_bus = bus_en ? bus_out : 'z;
endmodule

// File: tb/tb_io_interrupt_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_io_interrupt_controller;
    localparam int unsigned NUM_IRQ   = 8;
    localparam int unsigned VEC_SHIFT = 2;
    localparam logic [15:0] LINE_MASK = 16'((1 << NUM_IRQ) - 1);

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    wire  [15:0]        d_bus;
    logic [15:0]        tb_data;
    logic               tb_drive;

    io_interrupt_controller_if io ();

    assign d_bus = tb_drive ? tb_data : 'z;

    io_interrupt_controller #(.NUM_IRQ(NUM_IRQ), .VEC_SHIFT(VEC_SHIFT)) dut (
        .clk(clk), .rst(rst), .io(io), .d_bus(d_bus), .irq_in(irq_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: register contents plus two flags (request outstanding, being serviced).
    logic [15:0] m_mask, m_pend, m_vbase, m_ret, m_hold, m_prev;
    logic        m_gie, m_irq, m_svc;
    logic [3:0]  m_active;

    function automatic int m_id();
        logic [15:0] mk;
        mk = m_pend & m_mask;
        for (int i = 0; i < int'(NUM_IRQ); i++) if (mk[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] m_vector();
        int v;
        v = int'(m_vbase) + m_id() * (1 << VEC_SHIFT);
        return 16'(v % 65536);
    endfunction

    function automatic logic [15:0] m_reg(input logic [3:0] a);
        case (a)
            4'd0:    return m_mask;
            4'd1:    return m_pend;
            4'd2:    return m_vbase;
            4'd3:    return {8'h00, m_active, 2'b00, m_svc, m_gie};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] m_bus();
        if (io.io_push_int_addr) return m_vector();
        if (io.io_push_retaddr)  return m_ret;
        if (io.io_push_ints)     return m_pend & m_mask;
        return m_hold;
    endfunction

    // Advance model and DUT by one clock using the inputs currently applied.
    task automatic cycle();
        logic [3:0]  a;
        logic [15:0] w1c, rise, ack_bit;
        logic        req, ack, eoi;
        int          id;
        a       = io.d_addr[3:0];
        req     = m_gie && ((m_pend & m_mask) != 16'h0);
        id      = m_id();
        ack     = m_irq && req && io.io_push_int_addr;
        eoi     = m_svc && io.io_write && a == 4'd4;
        w1c     = (io.io_write && a == 4'd1) ? tb_data : 16'h0;
        rise    = 16'(irq_in) & ~m_prev;
        ack_bit = ack ? (16'h1 << id) : 16'h0;
        if (rst) begin
            {m_mask, m_pend, m_vbase, m_ret, m_hold} = '0;
            {m_gie, m_irq, m_svc} = '0;
            m_active = '0;
        end else begin
            if (io.io_read)          m_hold = m_reg(a);
            if (io.io_store_retaddr) m_ret  = tb_data;
            if (io.io_write) begin
                if (a == 4'd0) m_mask  = tb_data & LINE_MASK;
                if (a == 4'd2) m_vbase = tb_data;
                if (a == 4'd3) m_gie   = tb_data[0];
            end
            m_pend = (m_pend & ~w1c & ~ack_bit) | rise;
            m_irq  = (ack || m_svc) ? 1'b0 : req;
            if (ack) begin
                m_svc    = 1'b1;
                m_active = 4'(id);
            end else if (eoi) begin
                m_svc = 1'b0;
            end
        end
        m_prev = rst ? 16'h0 : 16'(irq_in);
        @(posedge clk);
        #1;
        {io.io_read, io.io_write, io.io_push, io.io_store_retaddr} = '0;
        {io.io_push_retaddr, io.io_push_ints, io.io_push_int_addr} = '0;
        tb_drive = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io.io_write = 1'b1;
        io.d_addr   = {12'h000, a};
        tb_drive    = 1'b1;
        tb_data     = d;
        cycle();
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] v);
        io.io_read = 1'b1;
        io.d_addr  = {12'h000, a};
        cycle();
        io.io_push = 1'b1;
        #1;
        v = d_bus;
        cycle();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", io.io_interrupt); end
        tb_drive = 1'b1; tb_data = 16'h0000; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL reset_bus_release: got %h expected 0000", d_bus); end
        tb_drive = 1'b0;
        for (int unsigned a = 0; a < 4; a++) begin
            rd(4'(a), v);
            checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0000", a, v); end
        end
        io.io_push_retaddr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL reset_retaddr: got %h expected 0000", d_bus); end
        cycle();
    endtask

    task automatic test_basic();
        logic [15:0] v;
        wr(4'd0, 16'h0005); wr(4'd2, 16'h0100); wr(4'd3, 16'h0001);
        irq_in = 8'h04; cycle(); irq_in = 8'h00;
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL basic_irq_early: got %b expected 0", io.io_interrupt); end
        cycle();
        checks++; if (io.io_interrupt !== 1'b1) begin failures++; $display("FAIL basic_irq_raise: got %b expected 1", io.io_interrupt); end
        rd(4'd1, v);
        checks++; if (v !== 16'h0004) begin failures++; $display("FAIL basic_pending: got %h expected 0004", v); end
        io.io_push_int_addr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0108) begin failures++; $display("FAIL basic_vector: got %h expected 0108", d_bus); end
        cycle();
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL basic_irq_ack: got %b expected 0", io.io_interrupt); end
        rd(4'd1, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL basic_pending_clr: got %h expected 0000", v); end
        rd(4'd3, v);
        checks++; if (v !== 16'h0023) begin failures++; $display("FAIL basic_ctrl: got %h expected 0023", v); end
        wr(4'd4, 16'h0000);
    endtask

    task automatic test_priority();
        irq_in = 8'h05; cycle(); irq_in = 8'h00; cycle();
        io.io_push_int_addr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0100) begin failures++; $display("FAIL prio_first_vector: got %h expected 0100", d_bus); end
        cycle();
        wr(4'd4, 16'h0000);
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL prio_after_eoi: got %b expected 0", io.io_interrupt); end
        cycle();
        checks++; if (io.io_interrupt !== 1'b1) begin failures++; $display("FAIL prio_reassert: got %b expected 1", io.io_interrupt); end
        io.io_push_int_addr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0108) begin failures++; $display("FAIL prio_second_vector: got %h expected 0108", d_bus); end
        cycle();
        wr(4'd4, 16'h0000);
    endtask

    task automatic test_masked();
        logic [15:0] v;
        irq_in = 8'h02; cycle(); irq_in = 8'h00; cycle(); cycle();
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL masked_no_irq: got %b expected 0", io.io_interrupt); end
        rd(4'd1, v);
        checks++; if (v !== 16'h0002) begin failures++; $display("FAIL masked_pending: got %h expected 0002", v); end
        wr(4'd0, 16'h0007);
        cycle();
        checks++; if (io.io_interrupt !== 1'b1) begin failures++; $display("FAIL unmask_irq: got %b expected 1", io.io_interrupt); end
        io.io_push_ints = 1'b1; #1;
        checks++; if (d_bus !== 16'h0002) begin failures++; $display("FAIL push_ints: got %h expected 0002", d_bus); end
        cycle();
        io.io_push_int_addr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0104) begin failures++; $display("FAIL masked_vector: got %h expected 0104", d_bus); end
        cycle();
        wr(4'd4, 16'h0000);
    endtask

    task automatic test_retaddr_bus();
        logic [15:0] v;
        io.io_store_retaddr = 1'b1; tb_drive = 1'b1; tb_data = 16'h1234; cycle();
        io.io_push_retaddr = 1'b1; #1;
        checks++; if (d_bus !== 16'h1234) begin failures++; $display("FAIL retaddr: got %h expected 1234", d_bus); end
        cycle();
        rd(4'd2, v);
        checks++; if (v !== 16'h0100) begin failures++; $display("FAIL read_vbase: got %h expected 0100", v); end
        tb_drive = 1'b1; tb_data = 16'h0000; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL bus_release: got %h expected 0000", d_bus); end
        tb_drive = 1'b0;
        io.io_push_retaddr = 1'b1; io.io_push_ints = 1'b1; io.io_push = 1'b1; #1;
        checks++; if (d_bus !== 16'h1234) begin failures++; $display("FAIL push_prio_ret: got %h expected 1234", d_bus); end
        io.io_push_retaddr = 1'b0; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL push_prio_ints: got %h expected 0000", d_bus); end
        cycle();
    endtask

    task automatic test_w1c_race();
        logic [15:0] v;
        wr(4'd3, 16'h0000);
        irq_in = 8'h08; io.io_write = 1'b1; io.d_addr = 16'h0001; tb_drive = 1'b1; tb_data = 16'h0008;
        cycle(); irq_in = 8'h00;
        rd(4'd1, v);
        checks++; if (v !== 16'h0008) begin failures++; $display("FAIL w1c_race: got %h expected 0008", v); end
        wr(4'd2, 16'hFFFC); wr(4'd0, 16'h000F);
        io.io_push_int_addr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0008) begin failures++; $display("FAIL vector_wrap: got %h expected 0008", d_bus); end
        cycle();
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL idle_ack_irq: got %b expected 0", io.io_interrupt); end
        rd(4'd3, v);
        checks++; if (v !== 16'h0010) begin failures++; $display("FAIL idle_ack_ctrl: got %h expected 0010", v); end
        wr(4'd1, 16'h0008);
        rd(4'd1, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL w1c_clear: got %h expected 0000", v); end
    endtask

    task automatic test_reset_mid_service();
        logic [15:0] v;
        wr(4'd0, 16'h0003); wr(4'd3, 16'h0001);
        irq_in = 8'h03; cycle(); irq_in = 8'h00; cycle();
        io.io_push_int_addr = 1'b1; cycle();
        irq_in = 8'h01; cycle(); irq_in = 8'h00;
        rd(4'd1, v);
        checks++; if (v !== 16'h0003) begin failures++; $display("FAIL svc_pending: got %h expected 0003", v); end
        io.io_store_retaddr = 1'b1; tb_drive = 1'b1; tb_data = 16'hBEEF; cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        checks++; if (io.io_interrupt !== 1'b0) begin failures++; $display("FAIL rst_svc_irq: got %b expected 0", io.io_interrupt); end
        tb_drive = 1'b1; tb_data = 16'h0000; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL rst_svc_bus: got %h expected 0000", d_bus); end
        tb_drive = 1'b0;
        rd(4'd0, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_svc_mask: got %h expected 0000", v); end
        rd(4'd1, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL rst_svc_pending: got %h expected 0000", v); end
        io.io_push_retaddr = 1'b1; #1;
        checks++; if (d_bus !== 16'h0000) begin failures++; $display("FAIL rst_svc_retaddr: got %h expected 0000", d_bus); end
        cycle();
        wr(4'd0, 16'h0001); wr(4'd3, 16'h0001);
        irq_in = 8'h01; cycle(); irq_in = 8'h00; cycle();
        checks++; if (io.io_interrupt !== 1'b1) begin failures++; $display("FAIL rst_svc_idle: got %b expected 1", io.io_interrupt); end
        io.io_push_int_addr = 1'b1; cycle();
        wr(4'd4, 16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] exp_bus;
        int          mode;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0) irq_in = NUM_IRQ'($urandom());
            rst        = ($urandom_range(0, 249) == 0);
            io.d_addr  = 16'($urandom());
            io.d_addr[3:0] = 4'($urandom_range(0, 6));
            io.io_read = ($urandom_range(0, 3) == 0);
            mode       = rst ? 2 : int'($urandom_range(0, 2));
            if (mode == 0) begin
                tb_drive    = 1'b1;
                tb_data     = 16'($urandom());
                tb_data[0]  = ($urandom_range(0, 3) != 0);
                io.io_write = ($urandom_range(0, 1) == 1);
                io.io_store_retaddr = ($urandom_range(0, 3) == 0);
            end else if (mode == 1) begin
                io.io_push_int_addr = ($urandom_range(0, 2) == 0);
                io.io_push_retaddr  = ($urandom_range(0, 2) == 0);
                io.io_push_ints     = ($urandom_range(0, 2) == 0);
                io.io_push          = ($urandom_range(0, 2) == 0);
                if (!(io.io_push_int_addr || io.io_push_retaddr || io.io_push_ints)) io.io_push = 1'b1;
            end else begin
                tb_drive = 1'b1;
                tb_data  = 16'h0000;
            end
            #1;
            exp_bus = (mode == 1) ? m_bus() : tb_data;
            checks++; if (d_bus !== exp_bus) begin failures++; $display("FAIL rand_bus[%0d]: got %h expected %h", n, d_bus, exp_bus); end
            cycle();
            checks++; if (io.io_interrupt !== m_irq) begin failures++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, io.io_interrupt, m_irq); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        irq_in = '0;
        tb_drive = 1'b0;
        tb_data = '0;
        io.d_addr = '0;
        {io.io_read, io.io_write, io.io_push, io.io_store_retaddr} = '0;
        {io.io_push_retaddr, io.io_push_ints, io.io_push_int_addr} = '0;
        m_prev = '0;
        #2;
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_retaddr_bus();
        test_w1c_race();
        test_reset_mid_service();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
